// File: rtl/des_pkg.sv
// Shared DES constants: FIPS 46-3 permutation tables (1-based), S-box contents,
// the key rotation schedule, FSM encoding and the helpers that apply them.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFT[j] for rounds j = 1..16 stored at index j-1.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Each S-box is 64 nibbles, row-major (row*16 + col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX_T [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // FIPS bit n of a W-bit word lives at vector index W+1-n.
    function automatic logic [64:1] ip_perm(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 0; i < 64; i++) y[64-i] = x[65-IP_T[i]];
        return y;
    endfunction

    function automatic logic [64:1] fp_perm(input logic [64:1] x);
        logic [64:1] y;
        for (int i = 0; i < 64; i++) y[64-i] = x[65-FP_T[i]];
        return y;
    endfunction

    function automatic logic [48:1] e_expand(input logic [32:1] x);
        logic [48:1] y;
        for (int i = 0; i < 48; i++) y[48-i] = x[33-E_T[i]];
        return y;
    endfunction

    function automatic logic [32:1] p_perm(input logic [32:1] x);
        logic [32:1] y;
        for (int i = 0; i < 32; i++) y[32-i] = x[33-P_T[i]];
        return y;
    endfunction

    function automatic logic [56:1] pc1_perm(input logic [64:1] x);
        logic [56:1] y;
        for (int i = 0; i < 56; i++) y[56-i] = x[65-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [48:1] pc2_perm(input logic [56:1] x);
        logic [48:1] y;
        for (int i = 0; i < 48; i++) y[48-i] = x[57-PC2_T[i]];
        return y;
    endfunction

    // j in 1..16; the 4-bit wrap maps j=16 onto index 15.
    function automatic logic [1:0] shift_amt(input logic [4:0] j);
        logic [3:0] k;
        k = j[3:0] - 4'd1;
        return SHIFT[k];
    endfunction

    function automatic logic [28:1] rotl28(input logic [28:1] v, input logic [1:0] n);
        return (n == 2'd1) ? {v[27:1], v[28]} : {v[26:1], v[28:27]};
    endfunction

    function automatic logic [28:1] rotr28(input logic [28:1] v, input logic [1:0] n);
        return (n == 2'd1) ? {v[1], v[28:2]} : {v[2:1], v[28:3]};
    endfunction

    // Row is {a6,a1}, column is a5..a2.
    function automatic logic [4:1] sbox_lookup(input logic [2:0] n, input logic [6:1] a);
        logic [7:0] pos;
        pos = 8'd255 - {a[6], a[1], a[5:2], 2'b00};
        return SBOX_T[n][pos -: 4];
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) ^ K)) and the eight S-box stages it uses.
module sbox1 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd0, a);
endmodule

module sbox2 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd1, a);
endmodule

module sbox3 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd2, a);
endmodule

module sbox4 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd3, a);
endmodule

module sbox5 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd4, a);
endmodule

module sbox6 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd5, a);
endmodule

module sbox7 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd6, a);
endmodule

module sbox8 import des_pkg::*; (input logic [6:1] a, output logic [4:1] y);
    assign y = sbox_lookup(3'd7, a);
endmodule

module des_f_function
    import des_pkg::*;
(
    input  logic [32:1] r,
    input  logic [48:1] k,
    output logic [32:1] f
);

    logic [48:1] x;
    logic [32:1] s;

    // Chunk 1 (the top six bits) feeds sbox1.
    assign x = e_expand(r) ^ k;

    sbox1 u_sbox1 (.a(x[48:43]), .y(s[32:29]));
    sbox2 u_sbox2 (.a(x[42:37]), .y(s[28:25]));
    sbox3 u_sbox3 (.a(x[36:31]), .y(s[24:21]));
    sbox4 u_sbox4 (.a(x[30:25]), .y(s[20:17]));
    sbox5 u_sbox5 (.a(x[24:19]), .y(s[16:13]));
    sbox6 u_sbox6 (.a(x[18:13]), .y(s[12:9]));
    sbox7 u_sbox7 (.a(x[12:7]),  .y(s[8:5]));
    sbox8 u_sbox8 (.a(x[6:1]),   .y(s[4:1]));

    assign f = p_perm(s);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block,
// encrypt/decrypt chosen per block, registered result.
module des_iter_core
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [64:1] key,
    input  logic [64:1] din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] dout,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid, once raised, holds its payload stable until that transfer.
    state_t      state, state_next;
    logic [32:1] l_reg, r_reg;
    logic [28:1] c_reg, d_reg;
    logic [28:1] c_rot, d_rot;
    logic [4:0]  rnd;
    logic        dir;
    logic [1:0]  sh_enc, sh_dec;
    logic [48:1] round_key;
    logic [32:1] f_out;
    logic        accept;
    logic        last_round;

    assign accept     = in_valid & in_ready;
    assign last_round = (rnd == 5'(NUM_ROUNDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == ROUND) || (state == DONE);
        dbg_state = state;
    end

    // Decrypt walks the schedule backwards: round 1 reuses C0/D0 (= C16/D16),
    // later rounds undo the encrypt shifts in reverse order.
    always_comb begin
        sh_enc = shift_amt(rnd);
        sh_dec = shift_amt(5'd18 - rnd);
        c_rot  = c_reg;
        d_rot  = d_reg;
        if (!dir) begin
            c_rot = rotl28(c_reg, sh_enc);
            d_rot = rotl28(d_reg, sh_enc);
        end else if (rnd != 5'd1) begin
            c_rot = rotr28(c_reg, sh_dec);
            d_rot = rotr28(d_reg, sh_dec);
        end
        round_key = pc2_perm({c_rot, d_rot});
    end

    des_f_function u_f (
        .r (r_reg),
        .k (round_key),
        .f (f_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            rnd       <= '0;
            dir       <= 1'b0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        {l_reg, r_reg} <= ip_perm(din);
                        {c_reg, d_reg} <= pc1_perm(key);
                        dir            <= decrypt;
                        rnd            <= 5'd1;
                    end
                end
                ROUND: begin
                    l_reg <= r_reg;
                    r_reg <= l_reg ^ f_out;
                    c_reg <= c_rot;
                    d_reg <= d_rot;
                    rnd   <= rnd + 5'd1;
                    // Final swap: output is FP(R16 || L16) built from this round's results.
                    if (last_round) begin
                        dout      <= fp_perm({l_reg ^ f_out, r_reg});
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core: known-answer vectors, latency, backpressure,
// mid-block reset and back-to-back throughput.
module tb_des_iter_core;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] C0 = 64'h8CA64DE9C1B123A7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [63:0] key;
    logic [63:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    des_iter_core #(.NUM_ROUNDS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .key       (key),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one block and returns at the negedge of the cycle after accept,
    // with the inputs already scrambled.
    task automatic send(input logic [63:0] k, input logic [63:0] d, input logic dec);
        int guard;
        @(negedge clk);
        key = k; din = d; decrypt = dec; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        key      = {$urandom, $urandom};
        din      = {$urandom, $urandom};
        decrypt  = 1'($urandom_range(0, 1));
    endtask

    // Counts cycles from accept (cycle 0) until out_valid is seen.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [63:0] held;
        int          c, got, acc_n;
        bit          sw_pend;
        logic [63:0] res [2];
        int          hs [2];
        int          acc [3];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        decrypt = 1'b0; key = '0; din = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Known-answer encrypt and latency.
        send(K1, P1, 1'b0);
        wait_out(lat);
        check("t1_latency", 64'(lat), 64'd17);
        check("t1_dout", dout, C1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd0);
        check("t1_state", 64'(dbg_state), 64'd2);
        take_out();
        check("t1_hs_in_ready", 64'(in_ready), 64'd1);
        check("t1_hs_out_valid", 64'(out_valid), 64'd0);

        // Decrypt back to the plaintext.
        send(K1, C1, 1'b1);
        wait_out(lat);
        check("t2_latency", 64'(lat), 64'd17);
        check("t2_dout", dout, P1);
        take_out();

        // All-zero key/data, both directions.
        send(64'd0, 64'd0, 1'b0);
        wait_out(lat);
        check("t3_enc_dout", dout, C0);
        take_out();
        send(64'd0, C0, 1'b1);
        wait_out(lat);
        check("t3_dec_dout", dout, 64'd0);
        take_out();

        // Backpressure with a stray in_valid pulse while DONE.
        send(K1, P1, 1'b0);
        wait_out(lat);
        check("t4_dout", dout, C1);
        held = dout;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; key = 64'd0; din = 64'd0; decrypt = 1'b0;
            end
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t4_hold_dout_%0d", i), dout, held);
            check($sformatf("t4_hold_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("t4_hold_in_ready_%0d", i), 64'(in_ready), 64'd0);
        end
        take_out();
        check("t4_hs_in_ready", 64'(in_ready), 64'd1);
        check("t4_hs_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t4_no_accept_busy", 64'(busy), 64'd0);
        check("t4_no_accept_state", 64'(dbg_state), 64'd0);

        // Reset during round 8, then a clean block.
        send(K1, P1, 1'b0);
        repeat (7) @(negedge clk);
        check("t5_busy_round8", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        check("t5_rst_dout", dout, 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        send(K1, P1, 1'b0);
        wait_out(lat);
        check("t5_latency", 64'(lat), 64'd17);
        check("t5_dout", dout, C1);
        take_out();

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        key = K1; din = P1; decrypt = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        c = 0; got = 0; acc_n = 0; sw_pend = 1'b0;
        hs[0] = 0; hs[1] = 0; acc[0] = 0; acc[1] = 0; acc[2] = 0;
        res[0] = '0; res[1] = '0;
        while (got < 2 && c < 200) begin
            if (sw_pend) begin
                key = 64'd0; din = 64'd0; sw_pend = 1'b0;
            end
            if (in_valid && in_ready && acc_n < 3) begin
                acc[acc_n] = c;
                acc_n++;
                if (acc_n == 1) sw_pend = 1'b1;
            end
            if (out_valid && out_ready) begin
                res[got] = dout;
                hs[got]  = c;
                got++;
            end
            if (got < 2) begin
                @(negedge clk);
                c++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("t6_outputs_seen", 64'(got), 64'd2);
        check("t6_accepts", 64'(acc_n), 64'd2);
        check("t6_first_dout", res[0], C1);
        check("t6_second_dout", res[1], C0);
        check("t6_first_latency", 64'(hs[0] - acc[0]), 64'd17);
        check("t6_second_accept_gap", 64'(acc[1] - hs[0]), 64'd1);
        check("t6_second_latency", 64'(hs[1] - acc[1]), 64'd17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
